// File: rtl/dram_req_frontend.sv
// dram_req_frontend
// Intake stage of the DRAM controller. L2 requests <address, offset> are
// buffered in a small FIFO. A splitter then expands each request into
// offset+1 consecutive burst-beat addresses, handing them one at a time to the
// controller FSM / address translator. New beats are held off while the
// refresh logic reports busy.
//
// Ports:
//   clk           single clock, rising edge
//   rst_b         asynchronous active-low reset
//   l2_req_val    request valid
//   l2_req        {address[ADDR_WIDTH], offset[OFFSET_WIDTH]}
//   l2_req_rdy    FIFO can accept (= !full)
//   refresh_busy  refresh in progress; blocks raising a new beat
//   addr_val      beat valid to controller
//   addr_out      beat address
//   addr_last     current beat is the last of its request
//   addr_ack      controller consumed the beat (qualified by addr_val)
//   req_count     FIFO occupancy
//   full, empty   FIFO status
//   idle          splitter idle and FIFO empty
module dram_req_frontend #(
    parameter int ADDR_WIDTH   = 13,
    parameter int OFFSET_WIDTH = 9,
    parameter int L2_REQ_WIDTH = 22,
    parameter int DEPTH        = 8
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      l2_req_val,
    input  logic [L2_REQ_WIDTH-1:0]   l2_req,
    output logic                      l2_req_rdy,
    input  logic                      refresh_busy,
    output logic                      addr_val,
    output logic [ADDR_WIDTH-1:0]     addr_out,
    output logic                      addr_last,
    input  logic                      addr_ack,
    output logic [$clog2(DEPTH):0]    req_count,
    output logic                      full,
    output logic                      empty,
    output logic                      idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    // ---------------- FIFO ----------------
    logic [L2_REQ_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [OFFSET_WIDTH-1:0] head_off;

    assign full       = (req_count == CNT_W'(DEPTH));
    assign empty      = (req_count == '0);
    assign l2_req_rdy = !full;
    // Gated by full alone, so a same-cycle pop never lets a push into a full FIFO.
    assign push       = l2_req_val && !full;
    assign head_addr  = mem[rd_ptr][L2_REQ_WIDTH-1:OFFSET_WIDTH];
    assign head_off   = mem[rd_ptr][OFFSET_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= l2_req;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   req_count <= req_count + CNT_W'(1);
                2'b01:   req_count <= req_count - CNT_W'(1);
                default: req_count <= req_count;
            endcase
        end
    end

    // ---------------- Splitter ----------------
    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [OFFSET_WIDTH-1:0] remaining;
    logic                    load;
    logic                    step;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cur_addr  <= head_addr;
                remaining <= head_off;
            end else if (step) begin
                cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                remaining <= remaining - OFFSET_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !refresh_busy) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (addr_ack) begin
                    if (remaining != '0) begin
                        step      = 1'b1;
                        state_nxt = refresh_busy ? S_WAIT : S_ISSUE;
                    end else if (!empty && !refresh_busy) begin
                        // Chain straight into the next request: no idle bubble.
                        pop       = 1'b1;
                        load      = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (!refresh_busy) begin
                    state_nxt = S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign addr_val  = (state == S_ISSUE);
    assign addr_out  = cur_addr;
    assign addr_last = addr_val && (remaining == '0);
    assign idle      = (state == S_IDLE) && empty;

endmodule

// File: tb/tb_dram_req_frontend.sv
// tb_dram_req_frontend
// Self-checking bench for dram_req_frontend. Every accepted request is
// expanded into its expected beats on a scoreboard queue; each consumed beat
// (addr_val && addr_ack) is popped and compared. A table of single requests
// checks beat count and final address; hand sequences cover latency,
// back-to-back chaining, backpressure, refresh interlock and reset mid-burst.
module tb_dram_req_frontend;

    logic        clk;
    logic        rst_b;
    logic        l2_req_val;
    logic [21:0] l2_req;
    logic        l2_req_rdy;
    logic        refresh_busy;
    logic        addr_val;
    logic [12:0] addr_out;
    logic        addr_last;
    logic        addr_ack;
    logic [3:0]  req_count;
    logic        full;
    logic        empty;
    logic        idle;

    dram_req_frontend #(
        .ADDR_WIDTH   (13),
        .OFFSET_WIDTH (9),
        .L2_REQ_WIDTH (22),
        .DEPTH        (8)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .l2_req_val   (l2_req_val),
        .l2_req       (l2_req),
        .l2_req_rdy   (l2_req_rdy),
        .refresh_busy (refresh_busy),
        .addr_val     (addr_val),
        .addr_out     (addr_out),
        .addr_last    (addr_last),
        .addr_ack     (addr_ack),
        .req_count    (req_count),
        .full         (full),
        .empty        (empty),
        .idle         (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned vec_cnt  = 0;
    int unsigned miss_cnt = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [12:0] addr;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       eb;
    int unsigned beat_cnt = 0;
    logic [12:0] last_beat_addr = '0;
    logic [12:0] m_base;
    int unsigned m_off;

    // Sample 1 time unit before each rising edge; stimulus changes on negedges.
    always @(negedge clk) begin
        #4;
        if (!rst_b) begin
            exp_q.delete();
        end else begin
            if (l2_req_val && l2_req_rdy) begin
                m_base = l2_req[21:9];
                m_off  = l2_req[8:0];
                for (int unsigned i = 0; i <= m_off; i++) begin
                    eb.addr = m_base + 13'(i);
                    eb.last = (i == m_off);
                    exp_q.push_back(eb);
                end
            end
            if (addr_val && addr_ack) begin
                beat_cnt++;
                last_beat_addr = addr_out;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {19'd0, addr_out}, 32'hFFFF_FFFF);
                end else begin
                    eb = exp_q.pop_front();
                    check("beat_addr", {19'd0, addr_out}, {19'd0, eb.addr});
                    check("beat_last", {31'd0, addr_last}, {31'd0, eb.last});
                end
            end
        end
    end

    // ---------------- helpers (start and end just after a negedge) ----------------
    task automatic push_req(input logic [12:0] a, input logic [8:0] o);
        int n = 0;
        l2_req_val = 1'b1;
        l2_req     = {a, o};
        while (!l2_req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", {31'd0, (n < 200)}, 32'd1);
        @(negedge clk);
        l2_req_val = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (!idle && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, (n < lim)}, 32'd1);
    endtask

    task automatic wait_val(input int lim);
        int n = 0;
        while (!addr_val && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("val_timeout", {31'd0, (n < lim)}, 32'd1);
    endtask

    typedef struct {
        logic [12:0] addr;
        logic [8:0]  off;
        int unsigned nbeats;
        logic [12:0] last_addr;
    } vec_t;

    vec_t        tbl [6];
    int unsigned c0;
    int          accepted;

    initial begin
        tbl[0] = '{addr: 13'h0010, off: 9'd0,   nbeats: 1,   last_addr: 13'h0010};
        tbl[1] = '{addr: 13'h1FFE, off: 9'd3,   nbeats: 4,   last_addr: 13'h0001};
        tbl[2] = '{addr: 13'h0AAA, off: 9'd7,   nbeats: 8,   last_addr: 13'h0AB1};
        tbl[3] = '{addr: 13'h1FFF, off: 9'd0,   nbeats: 1,   last_addr: 13'h1FFF};
        tbl[4] = '{addr: 13'h0000, off: 9'd511, nbeats: 512, last_addr: 13'h01FF};
        tbl[5] = '{addr: 13'h1F00, off: 9'd300, nbeats: 301, last_addr: 13'h002C};

        rst_b        = 1'b0;
        l2_req_val   = 1'b0;
        l2_req       = '0;
        refresh_busy = 1'b0;
        addr_ack     = 1'b0;
        #1;
        check("rst_addr_val",  {31'd0, addr_val},   32'd0);
        check("rst_addr_out",  {19'd0, addr_out},   32'd0);
        check("rst_addr_last", {31'd0, addr_last},  32'd0);
        check("rst_rdy",       {31'd0, l2_req_rdy}, 32'd1);
        check("rst_empty",     {31'd0, empty},      32'd1);
        check("rst_full",      {31'd0, full},       32'd0);
        check("rst_idle",      {31'd0, idle},       32'd1);
        check("rst_count",     {28'd0, req_count},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        // Latency: push on edge N, beat visible after N+1, idle after N+2.
        addr_ack = 1'b1;
        push_req(13'h0010, 9'd0);
        check("lat_val_n",    {31'd0, addr_val},  32'd0);
        check("lat_empty_n",  {31'd0, empty},     32'd0);
        @(negedge clk);
        check("lat_val",      {31'd0, addr_val},  32'd1);
        check("lat_addr",     {19'd0, addr_out},  32'h0010);
        check("lat_last",     {31'd0, addr_last}, 32'd1);
        @(negedge clk);
        check("lat_idle",     {31'd0, idle},      32'd1);
        check("lat_val_off",  {31'd0, addr_val},  32'd0);

        // Table of single requests with ack held high.
        for (int i = 0; i < 6; i++) begin
            c0 = beat_cnt;
            push_req(tbl[i].addr, tbl[i].off);
            wait_idle(700);
            check("tbl_nbeats",    beat_cnt - c0, tbl[i].nbeats);
            check("tbl_last_addr", {19'd0, last_beat_addr}, {19'd0, tbl[i].last_addr});
        end

        // Back-to-back requests chain without a bubble.
        push_req(13'h0100, 9'd1);
        push_req(13'h0200, 9'd0);
        check("b2b_addr0", {19'd0, addr_out}, 32'h0100);
        check("b2b_last0", {31'd0, addr_last}, 32'd0);
        @(negedge clk);
        check("b2b_val1",  {31'd0, addr_val}, 32'd1);
        check("b2b_addr1", {19'd0, addr_out}, 32'h0101);
        check("b2b_last1", {31'd0, addr_last}, 32'd1);
        @(negedge clk);
        check("b2b_val2",  {31'd0, addr_val}, 32'd1);
        check("b2b_addr2", {19'd0, addr_out}, 32'h0200);
        check("b2b_last2", {31'd0, addr_last}, 32'd1);
        @(negedge clk);
        check("b2b_idle",  {31'd0, idle}, 32'd1);

        // Backpressure: 10 back-to-back pushes with no ack.
        addr_ack   = 1'b0;
        accepted   = 0;
        l2_req_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            l2_req = {13'h0300 + 13'(i), 9'd0};
            if (l2_req_rdy) accepted++;
            @(negedge clk);
        end
        check("bp_accepted", accepted, 32'd9);
        check("bp_count",    {28'd0, req_count},  32'd8);
        check("bp_full",     {31'd0, full},       32'd1);
        check("bp_rdy",      {31'd0, l2_req_rdy}, 32'd0);
        check("bp_val",      {31'd0, addr_val},   32'd1);
        check("bp_addr",     {19'd0, addr_out},   32'h0300);
        addr_ack = 1'b1;
        @(negedge clk);
        addr_ack = 1'b0;
        check("bp_push_blocked", {28'd0, req_count}, 32'd7);
        check("bp_next_addr",    {19'd0, addr_out},  32'h0301);
        @(negedge clk);
        l2_req_val = 1'b0;
        check("bp_refill", {28'd0, req_count}, 32'd8);
        addr_ack = 1'b1;
        wait_idle(100);
        check("bp_sb_empty", exp_q.size(), 32'd0);

        // Refresh interlock.
        addr_ack = 1'b0;
        push_req(13'h0400, 9'd2);
        wait_val(10);
        refresh_busy = 1'b1;
        @(negedge clk);
        check("rf_hold_val",  {31'd0, addr_val}, 32'd1);
        check("rf_hold_addr", {19'd0, addr_out}, 32'h0400);
        addr_ack = 1'b1;
        @(negedge clk);
        check("rf_wait_val0", {31'd0, addr_val}, 32'd0);
        @(negedge clk);
        check("rf_wait_val1", {31'd0, addr_val}, 32'd0);
        refresh_busy = 1'b0;
        @(negedge clk);
        check("rf_resume_val",  {31'd0, addr_val}, 32'd1);
        check("rf_resume_addr", {19'd0, addr_out}, 32'h0401);
        wait_idle(20);
        refresh_busy = 1'b1;
        push_req(13'h0500, 9'd0);
        @(negedge clk);
        @(negedge clk);
        check("rf_idle_noload", {31'd0, addr_val},  32'd0);
        check("rf_idle_count",  {28'd0, req_count}, 32'd1);
        refresh_busy = 1'b0;
        wait_idle(20);
        check("rf_sb_empty", exp_q.size(), 32'd0);

        // Reset mid-burst with three requests queued.
        addr_ack = 1'b0;
        push_req(13'h0600, 9'd5);
        push_req(13'h0700, 9'd0);
        push_req(13'h0701, 9'd0);
        push_req(13'h0702, 9'd0);
        check("mr_count", {28'd0, req_count}, 32'd3);
        addr_ack = 1'b1;
        @(negedge clk);
        check("mr_beat2", {19'd0, addr_out}, 32'h0601);
        rst_b = 1'b0;
        #1;
        check("mr_val",   {31'd0, addr_val},   32'd0);
        check("mr_addr",  {19'd0, addr_out},   32'd0);
        check("mr_last",  {31'd0, addr_last},  32'd0);
        check("mr_rdy",   {31'd0, l2_req_rdy}, 32'd1);
        check("mr_empty", {31'd0, empty},      32'd1);
        check("mr_idle",  {31'd0, idle},       32'd1);
        check("mr_count0",{28'd0, req_count},  32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mr_quiet", {31'd0, addr_val}, 32'd0);
        end
        push_req(13'h0800, 9'd1);
        wait_idle(20);
        check("mr_last_addr", {19'd0, last_beat_addr}, 32'h0801);
        check("mr_sb_empty",  exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
